// File: rtl/aes_pkg.sv
// Shared AES definitions: the inverse-cipher FSM states, round count, key-index width,
// the inverse S-box and the GF(2^8) helper, all reused by the encrypt path.
package aes_pkg;

    localparam int NR        = 10;
    localparam int KEY_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mixcolumns.sv
// Combinational InvMixColumns over a full 128-bit column-major AES state.
module inv_mixcolumns
    import aes_pkg::*;
(
    input  logic [127:0] state,
    output logic [127:0] result
);

    // Coefficients 0e/0b/0d/09 built from x2, x4, x8 multiples.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a   [4];
        logic [7:0] m9  [4];
        logic [7:0] mb  [4];
        logic [7:0] md  [4];
        logic [7:0] me  [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign result[127-32*gi -: 32] = inv_mix_col(state[127-32*gi -: 32]);
        end
    endgenerate

endmodule

// File: rtl/inv_cipher.sv
// Iterative AES-128 inverse cipher: one round per clock, 11 cycles per block,
// round keys fetched from an external key store addressed by keyIdx.
module inv_cipher
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [127:0]         in,
    input  logic [127:0]         roundKey,
    output logic [KEY_IDX_W-1:0] keyIdx,
    output logic                 busy,
    output logic                 done,
    output logic [127:0]         out
);

    localparam logic [KEY_IDX_W-1:0] KEY_FIRST = KEY_IDX_W'(NR);

    state_t               state_reg, state_next;
    logic [127:0]         stm_reg, stm_next;
    logic [127:0]         out_reg, out_next;
    logic [KEY_IDX_W-1:0] key_idx_reg, key_idx_next;
    logic                 done_reg, done_next;

    logic [127:0] sub_rows;
    logic [127:0] keyed;
    logic [127:0] mixed;

    // InvShiftRows rotates row r right by r, so s'(r,c) = s(r,(c-r) mod 4); then InvSubBytes.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            localparam int SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;
            assign sub_rows[127-8*gi -: 8] = INV_SBOX[stm_reg[127-8*SRC -: 8]];
        end
    endgenerate

    assign keyed = sub_rows ^ roundKey;

    inv_mixcolumns u_inv_mixcolumns (
        .state  (keyed),
        .result (mixed)
    );

    always_comb begin
        state_next   = state_reg;
        stm_next     = stm_reg;
        out_next     = out_reg;
        key_idx_next = key_idx_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    stm_next     = in ^ roundKey;
                    key_idx_next = KEY_FIRST - 1'b1;
                    state_next   = ROUND;
                end
            end
            ROUND: begin
                stm_next     = mixed;
                key_idx_next = key_idx_reg - 1'b1;
                if (key_idx_reg == KEY_IDX_W'(1)) begin
                    state_next = FINAL;
                end
            end
            FINAL: begin
                out_next     = keyed;
                done_next    = 1'b1;
                key_idx_next = KEY_FIRST;
                state_next   = IDLE;
            end
            default: begin
                key_idx_next = KEY_FIRST;
                state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            stm_reg     <= '0;
            out_reg     <= '0;
            key_idx_reg <= KEY_FIRST;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            stm_reg     <= stm_next;
            out_reg     <= out_next;
            key_idx_reg <= key_idx_next;
            done_reg    <= done_next;
        end
    end

    assign keyIdx = key_idx_reg;
    assign done   = done_reg;
    assign out    = out_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_inv_cipher.sv
// Bench for inv_cipher: forward-AES reference and cycle-level timing model, directed vectors.
module tb_inv_cipher;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [127:0] in_blk = '0;
    logic [127:0] round_key;
    logic [3:0]   key_idx;
    logic         busy;
    logic         done;
    logic [127:0] out_blk;

    logic [127:0] rk [0:10];
    logic [7:0]   sbox [0:255];
    logic [127:0] exp_pt = '0;

    int checks = 0;
    int errors = 0;

    // Timing model: cycles left in the current block, pending and presented results.
    int           m_cnt  = 0;
    logic         m_done = 1'b0;
    logic [127:0] m_out  = '0;
    logic [127:0] m_pend = '0;

    always #5 clk = ~clk;

    assign round_key = (key_idx <= 4'd10) ? rk[key_idx] : '0;

    inv_cipher dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in       (in_blk),
        .roundKey (round_key),
        .keyIdx   (key_idx),
        .busy     (busy),
        .done     (done),
        .out      (out_blk)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // Forward S-box from first principles: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x] = s;
        end
    endtask

    task automatic set_key(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Forward AES-128 with the currently loaded key schedule.
    function automatic logic [127:0] enc(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_out  <= '0;
        end else if (m_cnt == 0) begin
            m_done <= 1'b0;
            if (start) begin
                m_cnt  <= 10;
                m_pend <= exp_pt;
            end
        end else begin
            m_cnt  <= m_cnt - 1;
            m_done <= (m_cnt == 1);
            if (m_cnt == 1) m_out <= m_pend;
        end
    end

    always @(negedge clk) begin
        chk("busy",   {127'd0, busy}, {127'd0, m_cnt != 0});
        chk("keyIdx", {124'd0, key_idx}, (m_cnt == 0) ? 128'd10 : 128'(m_cnt - 1));
        chk("done",   {127'd0, done}, {127'd0, m_done});
        chk("out",    out_blk, m_out);
    end

    task automatic start_block(input logic [127:0] ct, input logic [127:0] pt);
        in_blk = ct;
        exp_pt = pt;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 128'd0, 128'd1);
    endtask

    initial begin
        int n;
        int dn;
        logic [127:0] k, p;

        build_sbox();
        set_key(K1);
        repeat (3) @(negedge clk);
        chk("reset_keyIdx", {124'd0, key_idx}, 128'd10);
        chk("reset_out", out_blk, 128'd0);
        reset = 1'b1;
        @(negedge clk);

        // Vector 1, with the reference model pinned to published values.
        chk("k1_rk10", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("k1_enc", enc(P1), C1);
        start_block(C1, P1);
        wait_done(n);
        chk("v1_latency", 128'(n), 128'd10);
        chk("v1_out", out_blk, P1);
        @(negedge clk);

        // Vector 2 with explicit key-index sequence.
        set_key(K2);
        chk("k2_rk10", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("k2_enc", enc(P2), C2);
        chk("idle_keyIdx", {124'd0, key_idx}, 128'd10);
        start_block(C2, P2);
        for (int i = 9; i >= 0; i--) begin
            chk("v2_keyseq", {124'd0, key_idx}, 128'(i));
            @(negedge clk);
        end
        chk("v2_keyseq_end", {124'd0, key_idx}, 128'd10);
        chk("v2_done", {127'd0, done}, 128'd1);
        chk("v2_out", out_blk, P2);
        @(negedge clk);

        // Back-to-back: second start in the done cycle.
        set_key(K1);
        start_block(C1, P1);
        wait_done(n);
        chk("b2b_first", out_blk, P1);
        set_key(K2);
        start_block(C2, P2);
        chk("b2b_hold", out_blk, P1);
        wait_done(n);
        chk("b2b_spacing", 128'(n + 1), 128'd11);
        chk("b2b_second", out_blk, P2);
        @(negedge clk);

        // Starts while busy are ignored.
        set_key(K1);
        start_block(C1, P1);
        dn = 0;
        for (int c = 1; c <= 25; c++) begin
            start  = (c == 3 || c == 7);
            in_blk = start ? 128'hdeadbeefdeadbeefdeadbeefdeadbeef : C1;
            @(negedge clk);
            if (done) dn++;
        end
        start = 1'b0;
        chk("ignore_done_count", 128'(dn), 128'd1);
        chk("ignore_out", out_blk, P1);

        // Asynchronous reset mid-block, then an immediate restart.
        start_block(C2, P2);
        set_key(K2);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_busy", {127'd0, busy}, 128'd0);
        chk("async_done", {127'd0, done}, 128'd0);
        chk("async_keyIdx", {124'd0, key_idx}, 128'd10);
        chk("async_out", out_blk, 128'd0);
        @(negedge clk);
        set_key(K1);
        reset = 1'b1;
        start_block(C1, P1);
        wait_done(n);
        chk("post_reset_latency", 128'(n), 128'd10);
        chk("post_reset_out", out_blk, P1);
        @(negedge clk);

        // start held high: a new block on every return to IDLE.
        in_blk = C1;
        exp_pt = P1;
        start  = 1'b1;
        dn = 0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        start = 1'b0;
        chk("held_start_dones", 128'(dn), 128'd3);
        wait_done(n);
        chk("held_start_out", out_blk, P1);
        @(negedge clk);

        // Encrypt/decrypt loopback on random keys and blocks.
        for (int t = 0; t < 1000; t++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            set_key(k);
            start_block(enc(p), p);
            wait_done(n);
            chk("loopback", out_blk, p);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_cipher.md
INV_CIPHER -- requirements
Module: inv_cipher

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low clears all state immediately.
REQ-004 start  input  1  request to decrypt in; sampled only in IDLE.
REQ-005 in  input  128  ciphertext block; sampled on the accepting edge only.
REQ-006 roundKey  input  128  expanded AES-128 round key for index keyIdx, supplied combinationally by the key store.
REQ-007 keyIdx  output  4  round-key index requested this cycle (10 down to 0).
REQ-008 busy  output  1  high while a block is in progress (ROUND, FINAL).
REQ-009 done  output  1  one-cycle pulse; out is valid from this cycle on.
REQ-010 out  output  128  recovered plaintext; held until the next accepted start.

Function
REQ-011 The state machine SHALL have states IDLE, ROUND and FINAL.
REQ-012 In IDLE, keyIdx SHALL equal 10; start=1 at an edge loads stm = in ^ roundKey, sets keyIdx to 9 and moves to ROUND.
REQ-013 In ROUND, each edge SHALL load stm = InvMixColumns(InvSubBytes(InvShiftRows(stm)) ^ roundKey) and decrement keyIdx.
REQ-014 ROUND SHALL move to FINAL on the edge where keyIdx==1, leaving keyIdx=0.
REQ-015 In FINAL, the edge SHALL load out = InvSubBytes(InvShiftRows(stm)) ^ roundKey (key 0), pulse done for the following cycle, set keyIdx=10 and return to IDLE.
REQ-016 Latency SHALL be fixed: start accepted at edge N -> done high and out valid after edge N+10; throughput one block per 11 cycles.
REQ-017 start while busy=1 SHALL be ignored, with no effect on stm, keyIdx or out.
REQ-018 start high in the same cycle as done (state IDLE) SHALL be accepted, giving back-to-back blocks; out keeps the previous result until the new FINAL edge.
REQ-019 start held high continuously SHALL start a new block on every return to IDLE.
REQ-020 done SHALL never be high for more than one consecutive cycle per block.
REQ-021 All byte arithmetic SHALL be in GF(2^8) with reduction polynomial 0x11B; InvMixColumns coefficients SHALL be {0e,0b,0d,09}.
REQ-022 Byte and column ordering of in, out and roundKey SHALL match the encrypt-side cipher: bits [127:120] are state byte s(0,0), column-major.

Reset
REQ-023 While reset=0, the block SHALL hold: state IDLE, stm 0, out 0, done 0, busy 0, keyIdx 10.
REQ-024 Reset asserted mid-block SHALL abort the block with no done pulse; after release the block SHALL accept a new start on the first edge.
REQ-025 No output SHALL depend on clk-synchronous reset logic.

Structure
REQ-026 Package aes_pkg SHALL hold the state enum, NR=10, the keyIdx width and the inverse S-box table, shared with the encrypt path.
REQ-027 inv_mixcolumns SHALL be a separate sub-module (single 128-bit combinational transform). InvSubBytes and InvShiftRows SHALL be inline or small leaf modules.
REQ-028 The implementation SHALL contain one sequential process, with next-state and datapath logic purely combinational.

Verification
REQ-029 Key 000102030405060708090a0b0c0d0e0f, in 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> done 10 edges later, out 00112233445566778899aabbccddeeff.
REQ-030 Key 2b7e151628aed2a6abf7158809cf4f3c, in 3925841d02dc09fbdc118597196a0b32 -> out 3243f6a8885a308d313198a2e0370734. The keyIdx sequence SHALL be 10,9,...,0 exactly.
REQ-031 Back-to-back: run REQ-029, then start asserted in the done cycle with the REQ-030 block -> both results correct, and the second done 11 cycles after the first.
REQ-032 Start pulsed at cycles 3 and 7 of a busy block -> ignored; a single done with the REQ-029 result.
REQ-033 Reset driven low at cycle 5 of a block, asynchronously between edges -> outputs take reset values immediately; no done; the REQ-029 vector then completes correctly.
REQ-034 Encrypt/decrypt loopback: 1000 random keys and blocks through the encrypt cipher then inv_cipher -> out equals the original plaintext every time.
